// File: rtl/fcl_backward_if.sv
// Gradient stream toward the previous layer's backward stage (valid/ready).
interface fcl_backward_if #(
  parameter int unsigned IDX_W = 4
) ();
  logic [15:0]      grad_out;
  logic [IDX_W-1:0] grad_idx;
  logic             grad_valid;
  logic             grad_ready;

  modport master (output grad_out, output grad_idx, output grad_valid, input grad_ready);
  modport slave  (input grad_out, input grad_idx, input grad_valid, output grad_ready);
endinterface

// File: rtl/fcl_backward.sv
// Fully connected layer backward pass: grad[i] = sum_j W[j][i] * (mask[j] ? delta[j] : 0),
// one Q8.7 MAC per cycle, gradients streamed out one input neuron at a time.
module fcl_backward #(
  parameter int unsigned WIDTH               = 32,
  parameter int unsigned INPUT_NEURON_COUNT  = 15,
  parameter int unsigned OUTPUT_NEURON_COUNT = 15,
  parameter int unsigned FXP_FRAC_IN         = 7
) (
  input  logic                                                       clk,
  input  logic                                                       rst,
  input  logic                                                       start,
  input  logic [OUTPUT_NEURON_COUNT-1:0][15:0]                       delta,
  input  logic [OUTPUT_NEURON_COUNT-1:0]                             relu_mask,
  input  logic [OUTPUT_NEURON_COUNT-1:0][INPUT_NEURON_COUNT-1:0][15:0] weights,
  fcl_backward_if.master                                             grad,
  output logic                                                       busy,
  output logic                                                       done
);

  localparam int unsigned IDX_W = (INPUT_NEURON_COUNT > 1) ? $clog2(INPUT_NEURON_COUNT) : 1;
  localparam int unsigned J_W   = (OUTPUT_NEURON_COUNT > 1) ? $clog2(OUTPUT_NEURON_COUNT) : 1;
  // Worst-case sum of OUTPUT_NEURON_COUNT full-scale products cannot overflow this width.
  localparam int unsigned ACC_W = WIDTH + $clog2(OUTPUT_NEURON_COUNT) + 1;

  localparam logic [J_W-1:0]          J_LAST  = J_W'(OUTPUT_NEURON_COUNT - 1);
  localparam logic [IDX_W-1:0]        I_LAST  = IDX_W'(INPUT_NEURON_COUNT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

  state_t                                  state;
  logic [OUTPUT_NEURON_COUNT-1:0][15:0]    delta_q;
  logic [OUTPUT_NEURON_COUNT-1:0]          mask_q;
  logic [IDX_W-1:0]                        i_cnt;
  logic [J_W-1:0]                          j_cnt;
  logic signed [ACC_W-1:0]                 acc;

  logic signed [15:0]                      w_sel;
  logic signed [15:0]                      d_sel;
  logic signed [WIDTH-1:0]                 w_ext;
  logic signed [WIDTH-1:0]                 d_ext;
  logic signed [WIDTH-1:0]                 prod;
  logic signed [ACC_W-1:0]                 acc_sum;
  logic signed [ACC_W-1:0]                 acc_shr;
  logic [15:0]                             sat_val;

  // Current MAC term, running sum including it, and the rescaled/saturated result.
  always_comb begin
    w_sel   = weights[j_cnt][i_cnt];
    d_sel   = mask_q[j_cnt] ? delta_q[j_cnt] : 16'sd0;
    w_ext   = WIDTH'(w_sel);
    d_ext   = WIDTH'(d_sel);
    prod    = w_ext * d_ext;
    acc_sum = acc + ACC_W'(prod);
    acc_shr = acc_sum >>> FXP_FRAC_IN;
    sat_val = acc_shr[15:0];
    if (acc_shr > SAT_MAX) begin
      sat_val = 16'h7fff;
    end else if (acc_shr < SAT_MIN) begin
      sat_val = 16'h8000;
    end
  end

  // Control FSM with registered outputs; the gradient is registered on the last MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      delta_q         <= '0;
      mask_q          <= '0;
      i_cnt           <= '0;
      j_cnt           <= '0;
      acc             <= '0;
      grad.grad_out   <= '0;
      grad.grad_idx   <= '0;
      grad.grad_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            delta_q <= delta;
            mask_q  <= relu_mask;
            i_cnt   <= '0;
            j_cnt   <= '0;
            acc     <= '0;
            busy    <= 1'b1;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (j_cnt == J_LAST) begin
            grad.grad_valid <= 1'b1;
            grad.grad_out   <= sat_val;
            grad.grad_idx   <= i_cnt;
            state           <= S_EMIT;
          end else begin
            j_cnt <= j_cnt + J_W'(1);
          end
        end
        S_EMIT: begin
          if (grad.grad_ready) begin
            grad.grad_valid <= 1'b0;
            if (i_cnt == I_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              i_cnt <= i_cnt + IDX_W'(1);
              j_cnt <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fcl_backward.sv
// Bench for fcl_backward: directed vectors on a 2x2 instance, random passes on a 15x15 instance.
module tb_fcl_backward;

  localparam int NI   = 15;
  localparam int NO   = 15;
  localparam int FRAC = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 2x2 instance
  logic                  a_start;
  logic [1:0][15:0]      a_delta;
  logic [1:0]            a_mask;
  logic [1:0][1:0][15:0] a_w;
  logic                  a_busy, a_done;
  fcl_backward_if #(.IDX_W(1)) a_if ();

  fcl_backward #(.INPUT_NEURON_COUNT(2), .OUTPUT_NEURON_COUNT(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .delta(a_delta), .relu_mask(a_mask),
    .weights(a_w), .grad(a_if), .busy(a_busy), .done(a_done));

  // default 15x15 instance
  logic                    c_start;
  logic [NO-1:0][15:0]     c_delta;
  logic [NO-1:0]           c_mask;
  logic [NO-1:0][NI-1:0][15:0] c_w;
  logic                    c_busy, c_done;
  fcl_backward_if #(.IDX_W(4)) c_if ();

  fcl_backward u_c (
    .clk(clk), .rst(rst), .start(c_start), .delta(c_delta), .relu_mask(c_mask),
    .weights(c_w), .grad(c_if), .busy(c_busy), .done(c_done));

  typedef struct {
    logic [1:0][15:0]      delta;
    logic [1:0]            mask;
    logic [1:0][1:0][15:0] w;     // w[j][i]
    logic [1:0][15:0]      exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] m,
                              input logic [15:0] w00, input logic [15:0] w10,
                              input logic [15:0] w01, input logic [15:0] w11,
                              input logic [15:0] e0, input logic [15:0] e1);
    vec_t v;
    v.delta[0] = d0;  v.delta[1] = d1;  v.mask = m;
    v.w[0][0] = w00;  v.w[1][0] = w10;  v.w[0][1] = w01;  v.w[1][1] = w11;
    v.exp[0] = e0;    v.exp[1] = e1;
    return v;
  endfunction

  // Reference: plain integer dot product, floor-scaled and clamped to Q8.7 range.
  function automatic logic [15:0] model_grad(input logic [NO-1:0][15:0] d, input logic [NO-1:0] m,
                                             input logic [NO-1:0][NI-1:0][15:0] w, input int i);
    longint s;
    s = 0;
    for (int j = 0; j < NO; j++)
      if (m[j]) s += longint'($signed(w[j][i])) * longint'($signed(d[j]));
    s = s >>> FRAC;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // One pass on the 2x2 instance; optional backpressure of 'hold' cycles per gradient
  // and optional start pulses while busy. Inputs are scrambled right after acceptance.
  task automatic run_a(input int tag, input vec_t v, input int hold, input bit glitch);
    int cyc, n, held, first_cyc, done_cyc;
    logic [15:0] cap_v;
    logic        cap_i;
    @(posedge clk); #1;
    a_delta = v.delta; a_mask = v.mask; a_w = v.w; a_start = 1'b1;
    a_if.grad_ready = (hold == 0);
    cyc = 0; n = 0; held = 0; first_cyc = -1; done_cyc = -1; cap_v = '0; cap_i = 1'b0;
    while (done_cyc < 0 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      a_start = glitch && (cyc == 2 || cyc == 5);
      if (cyc == 1) begin a_delta = ~v.delta; a_mask = ~v.mask; end
      a_if.grad_ready = (hold == 0);
      if (a_done) done_cyc = cyc;
      if (a_if.grad_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held < hold) begin
          if (held == 0) begin
            cap_v = a_if.grad_out; cap_i = a_if.grad_idx;
          end else begin
            check($sformatf("v%0d hold val", tag), a_if.grad_out, cap_v);
            check($sformatf("v%0d hold idx", tag), a_if.grad_idx, cap_i);
          end
          held++;
        end else begin
          a_if.grad_ready = 1'b1;
          if (n < 2) begin
            check($sformatf("v%0d idx%0d index", tag, n), a_if.grad_idx, n);
            check($sformatf("v%0d idx%0d value", tag, n), a_if.grad_out, v.exp[n]);
          end else begin
            check($sformatf("v%0d extra grad", tag), n, 1);
          end
          n++;
          held = 0;
        end
      end
    end
    check($sformatf("v%0d done seen", tag), done_cyc >= 0, 1'b1);
    check($sformatf("v%0d grad count", tag), n, 2);
    if (hold == 0) begin
      check($sformatf("v%0d first valid cyc", tag), first_cyc, 3);
      check($sformatf("v%0d done cyc", tag), done_cyc, 7);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d done pulse width", tag), a_done, 1'b0);
    check($sformatf("v%0d busy after done", tag), a_busy, 1'b0);
    a_start = 1'b0; a_if.grad_ready = 1'b0;
  endtask

  // Random pass on the 15x15 instance with random backpressure.
  task automatic run_c(input int tag, input bit wide);
    logic [NO-1:0][15:0] d;
    logic [NO-1:0]       m;
    logic [15:0]         exp_q[NI];
    int cyc, n, done_cyc;
    bit r;
    for (int j = 0; j < NO; j++) begin
      d[j] = wide ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
      for (int i = 0; i < NI; i++)
        c_w[j][i] = wide ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
    end
    m = NO'($urandom);
    for (int i = 0; i < NI; i++) exp_q[i] = model_grad(d, m, c_w, i);
    @(posedge clk); #1;
    c_delta = d; c_mask = m; c_start = 1'b1; c_if.grad_ready = 1'b0;
    cyc = 0; n = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      c_start = 1'b0;
      if (cyc == 1) begin c_delta = ~d; c_mask = ~m; end
      if (c_done) done_cyc = cyc;
      r = ($urandom_range(0, 3) != 0);
      c_if.grad_ready = r;
      if (c_if.grad_valid && r) begin
        if (n < NI) begin
          check($sformatf("rnd%0d idx%0d index", tag, n), c_if.grad_idx, n);
          check($sformatf("rnd%0d idx%0d value", tag, n), c_if.grad_out, exp_q[n]);
        end else begin
          check($sformatf("rnd%0d extra grad", tag), n, NI - 1);
        end
        n++;
      end
    end
    check($sformatf("rnd%0d done seen", tag), done_cyc >= 0, 1'b1);
    check($sformatf("rnd%0d grad count", tag), n, NI);
    @(posedge clk); #1;
    c_if.grad_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_delta = '0; a_mask = '0; a_w = '0; a_if.grad_ready = 1'b0;
    c_start = 1'b0; c_delta = '0; c_mask = '0; c_w = '0; c_if.grad_ready = 1'b0;

    vecs[0] = mk(16'h0080, 16'h0100, 2'b11, 16'h0080, 16'h0040, 16'h0100, 16'hFF80, 16'h0100, 16'h0000);
    vecs[1] = mk(16'h0080, 16'h0100, 2'b01, 16'h0080, 16'h0040, 16'h0100, 16'hFF80, 16'h0080, 16'h0100);
    vecs[2] = mk(16'h0080, 16'h0100, 2'b00, 16'h0080, 16'h0040, 16'h0100, 16'hFF80, 16'h0000, 16'h0000);
    vecs[3] = mk(16'h7FFF, 16'h7FFF, 2'b11, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    vecs[4] = mk(16'h8000, 16'h8000, 2'b11, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000);
    vecs[5] = mk(16'h0080, 16'h0100, 2'b10, 16'h0080, 16'h0040, 16'h0100, 16'hFF80, 16'h0080, 16'hFF00);
    vecs[6] = mk(16'h0001, 16'h1234, 2'b01, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000);

    #1;
    check("reset grad_out", a_if.grad_out, 16'h0000);
    check("reset grad_idx", a_if.grad_idx, 1'b0);
    check("reset grad_valid", a_if.grad_valid, 1'b0);
    check("reset busy", a_busy, 1'b0);
    check("reset done", a_done, 1'b0);
    check("reset c valid", c_if.grad_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 7; k++) run_a(k, vecs[k], 0, 1'b0);

    run_a(10, vecs[0], 5, 1'b0);
    run_a(11, vecs[0], 0, 1'b1);

    // Reset during the MAC phase of the second gradient.
    @(posedge clk); #1;
    a_delta = vecs[0].delta; a_mask = vecs[0].mask; a_w = vecs[0].w;
    a_start = 1'b1; a_if.grad_ready = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", a_busy, 1'b1);
    check("pre-reset grad_out", a_if.grad_out, 16'h0100);
    rst = 1'b1;
    #1;
    check("mid reset grad_out", a_if.grad_out, 16'h0000);
    check("mid reset grad_idx", a_if.grad_idx, 1'b0);
    check("mid reset grad_valid", a_if.grad_valid, 1'b0);
    check("mid reset busy", a_busy, 1'b0);
    check("mid reset done", a_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("post reset no done %0d", k), a_done, 1'b0);
    end
    a_if.grad_ready = 1'b0;
    run_a(12, vecs[0], 0, 1'b0);

    for (int t = 0; t < 6; t++) run_c(t, (t % 3) == 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
